// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI4-Lite write-channel arbiter with per-transaction grant hold.
// Define AXI_ARB_RR_EN for round-robin tie-breaking; default build uses fixed priority (M0 wins).
module axi_wr_arbiter #(
    parameter int unsigned AXI_AWIDTH = 32,
    parameter int unsigned AXI_DWIDTH = 32
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESETN,

    input  logic [AXI_AWIDTH-1:0]   M0_AXI_AWADDR,
    input  logic                    M0_AXI_AWVALID,
    output logic                    M0_AXI_AWREADY,
    input  logic [AXI_DWIDTH-1:0]   M0_AXI_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] M0_AXI_WSTRB,
    input  logic                    M0_AXI_WVALID,
    output logic                    M0_AXI_WREADY,
    output logic [1:0]              M0_AXI_BRESP,
    output logic                    M0_AXI_BVALID,
    input  logic                    M0_AXI_BREADY,

    input  logic [AXI_AWIDTH-1:0]   M1_AXI_AWADDR,
    input  logic                    M1_AXI_AWVALID,
    output logic                    M1_AXI_AWREADY,
    input  logic [AXI_DWIDTH-1:0]   M1_AXI_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] M1_AXI_WSTRB,
    input  logic                    M1_AXI_WVALID,
    output logic                    M1_AXI_WREADY,
    output logic [1:0]              M1_AXI_BRESP,
    output logic                    M1_AXI_BVALID,
    input  logic                    M1_AXI_BREADY,

    output logic [AXI_AWIDTH-1:0]   S_AXI_AWADDR,
    output logic                    S_AXI_AWVALID,
    input  logic                    S_AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]   S_AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0] S_AXI_WSTRB,
    output logic                    S_AXI_WVALID,
    input  logic                    S_AXI_WREADY,
    input  logic [1:0]              S_AXI_BRESP,
    input  logic                    S_AXI_BVALID,
    output logic                    S_AXI_BREADY,

    output logic [1:0]              GRANT,
    output logic                    BUSY
);

    typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;

    state_e     state_q;
    logic [1:0] grant_q;
    logic       aw_done_q;
    logic       w_done_q;
    logic       last_grant_q;
    logic       busy_q;

    logic       sel;
    logic       in_addr;
    logic       in_xfer;
    logic       mg_awvalid;
    logic       mg_wvalid;
    logic       mg_bready;
    logic       aw_hs;
    logic       w_hs;
    logic       b_hs;
    logic       aw_done_nxt;
    logic       w_done_nxt;
    logic [1:0] req;
    logic       pick1;

    assign sel     = grant_q[1];
    assign in_addr = (state_q == StAddr);
    assign in_xfer = (state_q != StIdle);

    assign mg_awvalid = sel ? M1_AXI_AWVALID : M0_AXI_AWVALID;
    assign mg_wvalid  = sel ? M1_AXI_WVALID  : M0_AXI_WVALID;
    assign mg_bready  = sel ? M1_AXI_BREADY  : M0_AXI_BREADY;

    assign req[0] = M0_AXI_AWVALID | M0_AXI_WVALID;
    assign req[1] = M1_AXI_AWVALID | M1_AXI_WVALID;

`ifdef AXI_ARB_RR_EN
    // On a tie the master that did not complete last wins.
    assign pick1 = req[1] & (~req[0] | ~last_grant_q);
`else
    assign pick1 = req[1] & ~req[0];
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    always_comb begin
        S_AXI_AWADDR   = '0;
        S_AXI_WDATA    = '0;
        S_AXI_WSTRB    = '0;
        S_AXI_AWVALID  = 1'b0;
        S_AXI_WVALID   = 1'b0;
        S_AXI_BREADY   = 1'b0;
        M0_AXI_AWREADY = 1'b0;
        M0_AXI_WREADY  = 1'b0;
        M0_AXI_BVALID  = 1'b0;
        M0_AXI_BRESP   = 2'b00;
        M1_AXI_AWREADY = 1'b0;
        M1_AXI_WREADY  = 1'b0;
        M1_AXI_BVALID  = 1'b0;
        M1_AXI_BRESP   = 2'b00;

        // Payload is forced to zero while reset is asserted so every output reads 0.
        if (AXI_ARESETN) begin
            S_AXI_AWADDR = sel ? M1_AXI_AWADDR : M0_AXI_AWADDR;
            S_AXI_WDATA  = sel ? M1_AXI_WDATA  : M0_AXI_WDATA;
            S_AXI_WSTRB  = sel ? M1_AXI_WSTRB  : M0_AXI_WSTRB;
        end

        if (in_addr) begin
            S_AXI_AWVALID = mg_awvalid & ~aw_done_q;
            S_AXI_WVALID  = mg_wvalid & ~w_done_q;
            if (sel) begin
                M1_AXI_AWREADY = S_AXI_AWREADY & ~aw_done_q;
                M1_AXI_WREADY  = S_AXI_WREADY & ~w_done_q;
            end else begin
                M0_AXI_AWREADY = S_AXI_AWREADY & ~aw_done_q;
                M0_AXI_WREADY  = S_AXI_WREADY & ~w_done_q;
            end
        end

        if (in_xfer) begin
            S_AXI_BREADY = mg_bready;
            if (sel) begin
                M1_AXI_BVALID = S_AXI_BVALID;
                M1_AXI_BRESP  = S_AXI_BRESP;
            end else begin
                M0_AXI_BVALID = S_AXI_BVALID;
                M0_AXI_BRESP  = S_AXI_BRESP;
            end
        end
    end

    assign aw_hs       = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs        = S_AXI_WVALID & S_AXI_WREADY;
    assign b_hs        = S_AXI_BVALID & S_AXI_BREADY;
    assign aw_done_nxt = aw_done_q | aw_hs;
    assign w_done_nxt  = w_done_q | w_hs;

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state_q      <= StIdle;
            grant_q      <= 2'b00;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        grant_q   <= pick1 ? 2'b10 : 2'b01;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StAddr;
                    end
                end
                StAddr: begin
                    aw_done_q <= aw_done_nxt;
                    w_done_q  <= w_done_nxt;
                    if (aw_done_nxt && w_done_nxt) begin
                        if (b_hs) begin
                            grant_q      <= 2'b00;
                            last_grant_q <= sel;
                            busy_q       <= 1'b0;
                            state_q      <= StIdle;
                        end else begin
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (b_hs) begin
                        grant_q      <= 2'b00;
                        last_grant_q <= sel;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign GRANT = grant_q;
    assign BUSY  = busy_q;

endmodule
